// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, NB_DATA data bits LSB-first, optional parity, NB_STOP stop bits.
// Bit timing is 16 baud ticks per bit; o_tx, o_tx_done and o_busy are all registered.
module uart_tx #(
   parameter int unsigned NB_DATA = 8,
   parameter int unsigned NB_STOP = 1,
   parameter int unsigned PARITY  = 0
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_tx_data,
   output logic               o_tx,
   output logic               o_tx_done,
   output logic               o_busy
);

   localparam logic [4:0] BitLast  = 5'd15;
   localparam logic [4:0] StopLast = 5'(NB_STOP * 16 - 1);
   localparam logic [2:0] DataLast = 3'(NB_DATA - 1);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } state_e;

   state_e             state;
   logic [4:0]         tick_cnt;
   logic [2:0]         bit_cnt;
   logic [NB_DATA-1:0] shreg;
   logic               parity_bit;
   logic               tx_q;
   logic               done_q;
   logic               busy_q;
   logic               new_parity;

   assign new_parity = (PARITY == 1) ? ~(^i_tx_data) : (^i_tx_data);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= StIdle;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_bit <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               // The o_tx_done cycle is still part of the previous frame: no acceptance there.
               if (i_tx_start && !done_q) begin
                  shreg      <= i_tx_data;
                  parity_bit <= new_parity;
                  tick_cnt   <= '0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state      <= StStart;
               end
            end

            StStart: begin
               if (i_tick) begin
                  if (tick_cnt == BitLast) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     tx_q     <= shreg[0];
                     state    <= StData;
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end

            StData: begin
               if (i_tick) begin
                  if (tick_cnt == BitLast) begin
                     tick_cnt <= '0;
                     shreg    <= shreg >> 1;
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == DataLast) begin
                        if (PARITY != 0) begin
                           tx_q  <= parity_bit;
                           state <= StParity;
                        end else begin
                           tx_q  <= 1'b1;
                           state <= StStop;
                        end
                     end else begin
                        tx_q <= shreg[1];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end

            StParity: begin
               if (i_tick) begin
                  if (tick_cnt == BitLast) begin
                     tick_cnt <= '0;
                     tx_q     <= 1'b1;
                     state    <= StStop;
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end

            StStop: begin
               tx_q <= 1'b1;
               if (i_tick) begin
                  if (tick_cnt == StopLast) begin
                     tick_cnt <= '0;
                     done_q   <= 1'b1;
                     state    <= StIdle;
                  end else begin
                     tick_cnt <= tick_cnt + 5'd1;
                  end
               end
            end

            default: begin
               state    <= StIdle;
               tick_cnt <= '0;
               tx_q     <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_tx      = tx_q;
   assign o_tx_done = done_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: five parameter variants share clock, reset and baud tick;
// per-instance monitors decode the line against frames built from the frame-format rules.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int NDUT = 5;

   function automatic int cfg_nbd(input int k);
      return (k == 4) ? 5 : 8;
   endfunction

   function automatic int cfg_nst(input int k);
      return (k == 3 || k == 4) ? 2 : 1;
   endfunction

   function automatic int cfg_par(input int k);
      case (k)
         1: return 2;
         2: return 1;
         4: return 2;
         default: return 0;
      endcase
   endfunction

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tick = 1'b0;
   logic [NDUT-1:0] start;
   logic [NDUT-1:0] tx;
   logic [NDUT-1:0] done;
   logic [NDUT-1:0] busy;
   logic [7:0]      data [NDUT];

   int checks = 0;
   int errors = 0;
   int frames_seen [NDUT];
   int spur_done [NDUT];
   int spur_frame [NDUT];
   logic [7:0] exp_q [NDUT][$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned NBD = cfg_nbd(g);
      localparam int unsigned NST = cfg_nst(g);
      localparam int unsigned PAR = cfg_par(g);
      uart_tx #(
         .NB_DATA(NBD),
         .NB_STOP(NST),
         .PARITY (PAR)
      ) u_dut (
         .i_clk     (clk),
         .i_reset   (rst),
         .i_tick    (tick),
         .i_tx_start(start[g]),
         .i_tx_data (data[g][NBD-1:0]),
         .o_tx      (tx[g]),
         .o_tx_done (done[g]),
         .o_busy    (busy[g])
      );
   end

   // Baud tick with random spacing (sometimes back-to-back) to exercise hold-between-ticks.
   initial begin
      int gap;
      gap = 2;
      forever begin
         @(posedge clk);
         #1;
         if (gap == 0) begin
            tick = 1'b1;
            gap  = $urandom_range(0, 3);
         end else begin
            tick = 1'b0;
            gap--;
         end
      end
   end

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   function automatic int frame_len(input int k);
      return 1 + cfg_nbd(k) + ((cfg_par(k) != 0) ? 1 : 0) + cfg_nst(k);
   endfunction

   // Line level per bit slot: start, data LSB-first, optional parity, stop bits.
   function automatic logic [15:0] frame_pat(input int k, input logic [7:0] w);
      logic [15:0] p;
      logic        x;
      p    = '1;
      p[0] = 1'b0;
      x    = 1'b0;
      for (int i = 0; i < cfg_nbd(k); i++) begin
         p[1+i] = w[i];
         x      = x ^ w[i];
      end
      if (cfg_par(k) != 0) p[1+cfg_nbd(k)] = (cfg_par(k) == 2) ? x : ~x;
      return p;
   endfunction

   task automatic run_frame(input int k, input logic [7:0] w, input bit known);
      int          len;
      int          total;
      int          c;
      int          cyc;
      int          bad;
      bit          pend;
      logic [15:0] pat;
      logic [15:0] smp;
      logic [7:0]  got;
      logic [7:0]  mask;
      logic        stops;
      len   = frame_len(k);
      total = 16 * len;
      pat   = frame_pat(k, w);
      smp   = '0;
      c     = 0;
      cyc   = 0;
      bad   = 0;
      pend  = tick;
      forever begin
         if (c > 0 || cyc > 0) begin
            @(negedge clk);
            if (rst) return;
            if (pend) begin
               c++;
               if (c % 16 == 8 && c / 16 < len) smp[c/16] = tx[k];
            end
            pend = tick;
         end
         cyc++;
         if (c >= total) begin
            if (known) begin
               check("done_at_frame_end", k, 32'(done[k]), 32'd1);
               check("line_high_at_done", k, 32'(tx[k]), 32'd1);
               frames_seen[k]++;
            end
            break;
         end
         if (tx[k] !== pat[c/16] || done[k] !== 1'b0 || busy[k] !== 1'b1) bad++;
         if (cyc > total * 5 + 50) begin
            check("frame_timeout", k, 32'(c), 32'(total));
            return;
         end
      end
      if (!known) return;
      mask = 8'((1 << cfg_nbd(k)) - 1);
      got  = '0;
      for (int i = 0; i < cfg_nbd(k); i++) got[i] = smp[1+i];
      check("start_bit", k, 32'(smp[0]), 32'd0);
      check("data_word", k, 32'(got), 32'(w & mask));
      if (cfg_par(k) != 0)
         check("parity_bit", k, 32'(smp[1+cfg_nbd(k)]), 32'(pat[1+cfg_nbd(k)]));
      stops = 1'b1;
      for (int s = 0; s < cfg_nst(k); s++) stops = stops & smp[len-1-s];
      check("stop_bits", k, 32'(stops), 32'd1);
      check("line_trace_deviations", k, 32'(bad), 32'd0);
   endtask

   task automatic monitor(input int k);
      logic [7:0] w;
      forever begin
         @(negedge clk);
         if (rst) continue;
         if (done[k] === 1'b1) spur_done[k]++;
         if (tx[k] === 1'b0) begin
            if (exp_q[k].size() == 0) begin
               spur_frame[k]++;
               run_frame(k, 8'h00, 1'b0);
            end else begin
               w = exp_q[k].pop_front();
               run_frame(k, w, 1'b1);
            end
         end
      end
   endtask

   // All stimulus tasks are entered and left 1 ns after a rising edge.
   task automatic wait_ticks(input int n);
      int c;
      c = 0;
      while (c < n) begin
         @(posedge clk);
         if (tick) c++;
      end
      #1;
   endtask

   task automatic send(input int k, input logic [7:0] w, input bit expect_it);
      if (expect_it) exp_q[k].push_back(w);
      start[k] = 1'b1;
      data[k]  = w;
      @(posedge clk);
      #1;
      start[k] = 1'b0;
      data[k]  = 8'($urandom);
   endtask

   task automatic wait_frames(input int k, input int n);
      int cyc;
      cyc = 0;
      while (frames_seen[k] < n && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("frames_completed", k, 32'(frames_seen[k]), 32'(n));
   endtask

   task automatic wait_done(input int k);
      int cyc;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (done[k] !== 1'b1 && cyc < 5000);
      if (done[k] !== 1'b1) check("done_wait_timeout", k, 32'(cyc), 32'd0);
   endtask

   task automatic rand_run(input int k);
      int n;
      for (int i = 0; i < 4; i++) begin
         n = frames_seen[k];
         send(k, 8'($urandom), 1'b1);
         wait_frames(k, n + 1);
         n = $urandom_range(0, 3);
         repeat (n) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      start = '0;
      for (int k = 0; k < NDUT; k++) begin
         data[k]        = 8'h00;
         frames_seen[k] = 0;
         spur_done[k]   = 0;
         spur_frame[k]  = 0;
      end
      fork
         monitor(0);
         monitor(1);
         monitor(2);
         monitor(3);
         monitor(4);
      join_none
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < NDUT; k++) begin
         check("reset_tx", k, 32'(tx[k]), 32'd1);
         check("reset_busy", k, 32'(busy[k]), 32'd0);
         check("reset_done", k, 32'(done[k]), 32'd0);
      end
      wait_ticks(200);
      for (int k = 0; k < NDUT; k++) begin
         check("idle_tx", k, 32'(tx[k]), 32'd1);
         check("idle_busy", k, 32'(busy[k]), 32'd0);
      end

      send(0, 8'hA5, 1'b1);
      check("busy_after_accept", 0, 32'(busy[0]), 32'd1);
      wait_frames(0, 1);

      fork
         send(1, 8'h07, 1'b1);
         send(2, 8'h07, 1'b1);
      join
      wait_frames(1, 1);
      wait_frames(2, 1);

      // Requests mid-frame and in the done cycle must both be dropped.
      base = frames_seen[0];
      send(0, 8'h55, 1'b1);
      wait_ticks(50);
      send(0, 8'h3C, 1'b0);
      wait_done(0);
      start[0] = 1'b1;
      data[0]  = 8'h99;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      check("busy_after_done", 0, 32'(busy[0]), 32'd0);
      wait_ticks(40);
      check("no_retrigger_tx", 0, 32'(tx[0]), 32'd1);
      check("no_retrigger_busy", 0, 32'(busy[0]), 32'd0);
      check("single_frame", 0, 32'(frames_seen[0]), 32'(base + 1));

      // Reset in the middle of data bit 3.
      send(0, 8'h48, 1'b1);
      wait_ticks(16 * 4 + 8);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_tx", 0, 32'(tx[0]), 32'd1);
      check("abort_busy", 0, 32'(busy[0]), 32'd0);
      check("abort_done", 0, 32'(done[0]), 32'd0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      base = frames_seen[0];
      wait_ticks(300);
      check("aborted_frame_never_done", 0, 32'(frames_seen[0]), 32'(base));
      send(0, 8'h81, 1'b1);
      wait_frames(0, base + 1);

      // Back-to-back frames with the request held high, two stop bits.
      base = frames_seen[3];
      exp_q[3].push_back(8'h00);
      exp_q[3].push_back(8'hFF);
      exp_q[3].push_back(8'h5A);
      data[3]  = 8'h00;
      start[3] = 1'b1;
      wait_done(3);
      data[3] = 8'hFF;
      wait_done(3);
      data[3] = 8'h5A;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      start[3] = 1'b0;
      data[3]  = 8'h00;
      wait_frames(3, base + 3);

      fork
         rand_run(0);
         rand_run(1);
         rand_run(2);
         rand_run(3);
         rand_run(4);
      join

      wait_ticks(50);
      for (int k = 0; k < NDUT; k++) begin
         check("spurious_done", k, 32'(spur_done[k]), 32'd0);
         check("unexpected_frame", k, 32'(spur_frame[k]), 32'd0);
         check("pending_expected", k, 32'(exp_q[k].size()), 32'd0);
         check("final_tx", k, 32'(tx[k]), 32'd1);
         check("final_busy", k, 32'(busy[k]), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
